// File: rtl/main_mem_pkg.sv
// Shared definitions for the main_mem arbiter slice.
//   mm_state_t : sequencer state encoding (IDLE, ISSUE, WAIT)
//   MM_AW/MM_DW: default memory address / data widths
//   rr_pick()  : round-robin winner search, usable by any shared-resource arbiter
package main_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } mm_state_t;

  localparam int MM_AW     = 10;
  localparam int MM_DW     = 16;
  localparam int MM_MAXREQ = 8;
  localparam int MM_IDXW   = 3;

  // First set bit of req searching upward from ptr+1, wrapping modulo nreq.
  // Returns ptr when nothing is requested (callers qualify with |req).
  function automatic logic [MM_IDXW-1:0] rr_pick(
    input logic [MM_MAXREQ-1:0] req,
    input logic [MM_IDXW-1:0]   ptr,
    input int                   nreq
  );
    logic [MM_IDXW-1:0] win;
    logic               found;
    int                 idx;
    win   = ptr;
    found = 1'b0;
    for (int k = 1; k <= MM_MAXREQ; k++) begin
      idx = (int'(ptr) + k) % nreq;
      if (!found && (k <= nreq) && req[idx[MM_IDXW-1:0]]) begin
        win   = idx[MM_IDXW-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/main_mem_rr_pick.sv
// Combinational round-robin picker.
//   req : per-requester request vector
//   ptr : index of the previous winner (lowest priority this round)
//   win : index of the selected requester (valid when any=1)
//   any : at least one request present
module main_mem_rr_pick
  import main_mem_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   win,
  output logic            any
);

  logic [MM_MAXREQ-1:0] req_ext;
  logic [MM_IDXW-1:0]   ptr_ext;

  always_comb begin
    req_ext           = '0;
    req_ext[NREQ-1:0] = req;
    ptr_ext           = '0;
    ptr_ext[IW-1:0]   = ptr;
    win               = IW'(rr_pick(req_ext, ptr_ext, NREQ));
    any               = |req;
  end

endmodule

// File: rtl/main_mem_arb.sv
// Round-robin arbiter / sequencer that owns the single main_mem port.
//   clk, reset              : clock, asynchronous active-high reset
//   req/req_we/req_addr/
//   req_wdata               : per-requester level command (flattened buses)
//   gnt                     : one-hot pulse in the cycle the access is issued
//   rvalid, rdata           : one-hot read-return pulse, data held until next read
//   busy                    : sequencer not IDLE
//   mem_cs/mem_we/mem_addr/
//   mem_wdata/mem_rdata     : memory port, mem_rdata valid RD_LAT cycles after mem_cs
//   scan_*, test_mode       : DFT hooks, no functional use
module main_mem_arb
  import main_mem_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int AW     = MM_AW,
  parameter int DW     = MM_DW,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  rvalid,
  output logic [DW-1:0]    rdata,
  output logic             busy,
  output logic             mem_cs,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             scan_in0,
  input  logic             scan_enable,
  input  logic             test_mode,
  output logic             scan_out0
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [IW-1:0]   PTR_RST = IW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE     = NREQ'(1);

  mm_state_t        state, state_n;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    pick_win;
  logic             pick_any;
  logic [IW-1:0]    cmd_win_p1;
  logic             cmd_we_p1;
  logic [AW-1:0]    cmd_addr_p1;
  logic [DW-1:0]    cmd_wdata_p1;
  logic [CW-1:0]    cnt;
  logic [NREQ-1:0]  rvalid_p2;
  logic [DW-1:0]    rdata_p2;
  logic             unused_dft;

  main_mem_rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .win (pick_win),
    .any (pick_any)
  );

  always_comb begin
    state_n = state;
    gnt     = '0;
    mem_cs  = 1'b0;
    mem_we  = 1'b0;
    busy    = (state != IDLE);
    case (state)
      IDLE:    if (pick_any) state_n = ISSUE;
      ISSUE: begin
        mem_cs  = 1'b1;
        mem_we  = cmd_we_p1;
        gnt     = ONE << cmd_win_p1;
        state_n = cmd_we_p1 ? IDLE : WAIT;
      end
      WAIT:    if (cnt == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= PTR_RST;
      cmd_win_p1   <= '0;
      cmd_we_p1    <= 1'b0;
      cmd_addr_p1  <= '0;
      cmd_wdata_p1 <= '0;
      cnt          <= '0;
      rvalid_p2    <= '0;
      rdata_p2     <= '0;
    end else begin
      state     <= state_n;
      rvalid_p2 <= '0;
      case (state)
        // p1: latch the winning command; it is frozen until the next arbitration
        IDLE: begin
          if (pick_any) begin
            cmd_win_p1   <= pick_win;
            cmd_we_p1    <= req_we[pick_win];
            cmd_addr_p1  <= req_addr[pick_win*AW +: AW];
            cmd_wdata_p1 <= req_wdata[pick_win*DW +: DW];
            ptr          <= pick_win;
          end
        end
        ISSUE: cnt <= CW'(RD_LAT - 1);
        // p2: read return, captured in the last wait cycle
        WAIT: begin
          if (cnt == '0) begin
            rdata_p2  <= mem_rdata;
            rvalid_p2 <= ONE << cmd_win_p1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr   = cmd_addr_p1;
  assign mem_wdata  = cmd_wdata_p1;
  assign rvalid     = rvalid_p2;
  assign rdata      = rdata_p2;
  assign scan_out0  = 1'b0;
  assign unused_dft = scan_in0 ^ scan_enable ^ test_mode;

endmodule

// File: tb/tb_main_mem_arb.sv
// Directed bench: one RD_LAT=1 arbiter with a memory model, plus four
// arbiters with RD_LAT=1..4 driven by a latency-accurate read-only model.
module tb_main_mem_arb;

  logic        clk;
  logic        reset;
  int          checks = 0;
  int          errors = 0;

  // main DUT (RD_LAT=1)
  logic [3:0]  req, req_we;
  logic [39:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  gnt, rvalid;
  logic [15:0] rdata, mem_wdata, mem_rdata, rd_pipe;
  logic        busy, mem_cs, mem_we, scan_out0;
  logic [9:0]  mem_addr;
  logic [15:0] mem [0:1023];

  // latency lanes
  logic [3:0]  s_req    [4];
  logic [39:0] s_addr   [4];
  logic [3:0]  s_gnt    [4];
  logic [3:0]  s_rvalid [4];
  logic [15:0] s_rdata  [4];
  logic        s_busy   [4];
  logic        s_cs     [4];
  logic        s_we     [4];
  logic [9:0]  s_maddr  [4];
  logic [15:0] s_mwdata [4];
  logic [15:0] s_mrdata [4];
  logic        s_so     [4];

  function automatic logic [15:0] lane_data(input logic [9:0] a);
    return {a[7:0], ~a[7:0]};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  main_mem_arb #(.NREQ(4), .AW(10), .DW(16), .RD_LAT(1)) u_dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .scan_in0(1'b0), .scan_enable(1'b0), .test_mode(1'b0),
    .scan_out0(scan_out0)
  );

  // Memory model: data only present in the single cycle RD_LAT after mem_cs.
  always @(posedge clk) begin
    if (reset) mem[10'h03F] <= 16'hA5A5;
    else if (mem_cs && mem_we) mem[mem_addr] <= mem_wdata;
    rd_pipe <= (mem_cs && !mem_we) ? mem[mem_addr] : 16'hDEAD;
  end
  assign mem_rdata = rd_pipe;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [15:0] pipe [0:3];
    main_mem_arb #(.NREQ(4), .AW(10), .DW(16), .RD_LAT(g + 1)) u_lane (
      .clk(clk), .reset(reset), .req(s_req[g]), .req_we(4'b0000), .req_addr(s_addr[g]),
      .req_wdata(64'd0), .gnt(s_gnt[g]), .rvalid(s_rvalid[g]), .rdata(s_rdata[g]),
      .busy(s_busy[g]), .mem_cs(s_cs[g]), .mem_we(s_we[g]), .mem_addr(s_maddr[g]),
      .mem_wdata(s_mwdata[g]), .mem_rdata(s_mrdata[g]), .scan_in0(1'b0),
      .scan_enable(1'b0), .test_mode(1'b0), .scan_out0(s_so[g])
    );
    always @(posedge clk) begin
      pipe[0] <= (s_cs[g] && !s_we[g]) ? lane_data(s_maddr[g]) : 16'hDEAD;
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign s_mrdata[g] = pipe[g];
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, rvalid, rdata, busy, mem_cs, mem_we, mem_addr, mem_wdata, scan_out0} !== 52'd0) begin
      errors++;
      $display("FAIL reset_main: gnt=%b rvalid=%b rdata=%h busy=%b cs=%b we=%b addr=%h wdata=%h so=%b, all required 0",
               gnt, rvalid, rdata, busy, mem_cs, mem_we, mem_addr, mem_wdata, scan_out0);
    end
    for (int g = 0; g < 4; g++) begin
      checks++;
      if ({s_gnt[g], s_rvalid[g], s_rdata[g], s_busy[g], s_cs[g]} !== 26'd0) begin
        errors++;
        $display("FAIL reset_lane%0d: gnt=%b rvalid=%b rdata=%h busy=%b cs=%b, all required 0",
                 g, s_gnt[g], s_rvalid[g], s_rdata[g], s_busy[g], s_cs[g]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    req_we = 4'b0000;
    req_addr[20 +: 10] = 10'h03F;
    req = 4'b0100;
    @(negedge clk);
    checks++;
    if ({gnt, mem_cs, mem_we, mem_addr, busy} !== {4'b0100, 1'b1, 1'b0, 10'h03F, 1'b1}) begin
      errors++;
      $display("FAIL rd_issue: gnt=%b cs=%b we=%b addr=%h busy=%b, required 0100 1 0 03f 1",
               gnt, mem_cs, mem_we, mem_addr, busy);
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if ({gnt, rvalid, mem_cs, busy} !== {4'b0000, 4'b0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rd_wait: gnt=%b rvalid=%b cs=%b busy=%b, required 0000 0000 0 1",
               gnt, rvalid, mem_cs, busy);
    end
    @(negedge clk);
    checks++;
    if ({rvalid, rdata, busy} !== {4'b0100, 16'hA5A5, 1'b0}) begin
      errors++;
      $display("FAIL rd_return: rvalid=%b rdata=%h busy=%b, required 0100 a5a5 0", rvalid, rdata, busy);
    end
    @(negedge clk);
    checks++;
    if ({rvalid, rdata} !== {4'b0000, 16'hA5A5}) begin
      errors++;
      $display("FAIL rd_hold: rvalid=%b rdata=%h, required 0000 a5a5", rvalid, rdata);
    end
  endtask

  task automatic test_single_write();
    @(negedge clk);
    req_we = 4'b0010;
    req_addr[10 +: 10]  = 10'h100;
    req_wdata[16 +: 16] = 16'h1234;
    req = 4'b0010;
    @(negedge clk);
    checks++;
    if ({gnt, mem_cs, mem_we, mem_addr, mem_wdata, rvalid} !== {4'b0010, 1'b1, 1'b1, 10'h100, 16'h1234, 4'b0000}) begin
      errors++;
      $display("FAIL wr_issue: gnt=%b cs=%b we=%b addr=%h wdata=%h rvalid=%b, required 0010 1 1 100 1234 0000",
               gnt, mem_cs, mem_we, mem_addr, mem_wdata, rvalid);
    end
    req = 4'b0000;
    @(negedge clk);
    checks++;
    if ({gnt, mem_cs, mem_we, busy, mem_addr, mem_wdata} !== {4'b0000, 1'b0, 1'b0, 1'b0, 10'h100, 16'h1234}) begin
      errors++;
      $display("FAIL wr_after: gnt=%b cs=%b we=%b busy=%b addr=%h wdata=%h, required 0000 0 0 0 100 1234",
               gnt, mem_cs, mem_we, busy, mem_addr, mem_wdata);
    end
    checks++;
    if (mem[10'h100] !== 16'h1234) begin
      errors++;
      $display("FAIL wr_mem: mem[100]=%h, required 1234", mem[10'h100]);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (rvalid !== 4'b0000) begin
        errors++;
        $display("FAIL wr_no_rvalid: rvalid=%b, required 0000", rvalid);
      end
    end
  endtask

  task automatic test_withdrawal();
    @(negedge clk);
    req_we = 4'b0000;
    req_addr[0 +: 10]  = 10'h03F;
    req_addr[20 +: 10] = 10'h011;
    req = 4'b0001;
    @(negedge clk);
    checks++;
    if ({gnt, busy} !== {4'b0001, 1'b1}) begin
      errors++;
      $display("FAIL wd_gnt0: gnt=%b busy=%b, required 0001 1", gnt, busy);
    end
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if ({gnt, mem_cs} !== 5'b0) begin
        errors++;
        $display("FAIL wd_no_access: cycle %0d gnt=%b cs=%b, required 0000 0", c, gnt, mem_cs);
      end
      if (c == 1) begin
        checks++;
        if (rvalid !== 4'b0001) begin
          errors++;
          $display("FAIL wd_rvalid0: rvalid=%b, required 0001", rvalid);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fairness();
    logic [3:0] order [6];
    int n;
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b1000};
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_we = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*10 +: 10]  = 10'h200 + 10'(i);
      req_wdata[i*16 +: 16] = 16'h0100 + 16'(i);
    end
    req = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      @(negedge clk);
      while (gnt === 4'b0000 && n < 8) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (gnt !== order[k]) begin
        errors++;
        $display("FAIL fair_order%0d: gnt=%b, required %b", k, gnt, order[k]);
      end
      req = req & ~order[k];
      if (k == 3) req = 4'b1001;
    end
  endtask

  task automatic test_latency_sweep();
    int lat;
    logic busy_ok;
    logic [9:0] a;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      a = 10'h020 + 10'(g);
      s_addr[g][9:0] = a;
      s_req[g] = 4'b0001;
      @(negedge clk);
      lat = 1;
      checks++;
      if (s_gnt[g] !== 4'b0001) begin
        errors++;
        $display("FAIL lat%0d_gnt: gnt=%b, required 0001", g + 1, s_gnt[g]);
      end
      s_req[g] = 4'b0000;
      busy_ok = 1'b1;
      while (s_rvalid[g] === 4'b0000 && lat < 12) begin
        if (s_busy[g] !== 1'b1) busy_ok = 1'b0;
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat != g + 3) begin
        errors++;
        $display("FAIL lat%0d_cycles: rvalid after %0d cycles, required %0d", g + 1, lat, g + 3);
      end
      checks++;
      if (!busy_ok) begin
        errors++;
        $display("FAIL lat%0d_busy: busy dropped before read return, required high", g + 1);
      end
      checks++;
      if ({s_rvalid[g], s_rdata[g], s_busy[g]} !== {4'b0001, lane_data(a), 1'b0}) begin
        errors++;
        $display("FAIL lat%0d_data: rvalid=%b rdata=%h busy=%b, required 0001 %h 0",
                 g + 1, s_rvalid[g], s_rdata[g], s_busy[g], lane_data(a));
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic stale;
    logic seen;
    @(negedge clk);
    s_addr[3][10 +: 10] = 10'h055;
    s_addr[3][30 +: 10] = 10'h066;
    s_req[3] = 4'b0010;
    @(negedge clk);
    checks++;
    if (s_gnt[3] !== 4'b0010) begin
      errors++;
      $display("FAIL rst_mid_gnt: gnt=%b, required 0010", s_gnt[3]);
    end
    s_req[3] = 4'b0000;
    repeat (2) @(negedge clk);
    checks++;
    if (s_busy[3] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_busy: busy=%b, required 1", s_busy[3]);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({s_gnt[3], s_rvalid[3], s_cs[3], s_busy[3], s_rdata[3]} !== 26'd0) begin
      errors++;
      $display("FAIL rst_mid_async: gnt=%b rvalid=%b cs=%b busy=%b rdata=%h, all required 0",
               s_gnt[3], s_rvalid[3], s_cs[3], s_busy[3], s_rdata[3]);
    end
    @(negedge clk);
    reset = 1'b0;
    s_req[3] = 4'b1000;
    @(negedge clk);
    checks++;
    if (s_gnt[3] !== 4'b1000) begin
      errors++;
      $display("FAIL rst_after_gnt: gnt=%b, required 1000", s_gnt[3]);
    end
    s_req[3] = 4'b0000;
    stale = 1'b0;
    seen  = 1'b0;
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      if (c == 6 && s_rvalid[3] === 4'b1000 && s_rdata[3] === lane_data(10'h066)) seen = 1'b1;
      else if (s_rvalid[3] !== 4'b0000) stale = 1'b1;
    end
    checks++;
    if (!seen || stale) begin
      errors++;
      $display("FAIL rst_after_read: return seen=%b stale=%b, required seen=1 stale=0", seen, stale);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int g = 0; g < 4; g++) begin
      s_req[g]  = '0;
      s_addr[g] = '0;
    end
    test_reset();
    test_single_read();
    test_single_write();
    test_withdrawal();
    test_fairness();
    test_latency_sweep();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
